// File: rtl/clock_ui_pkg.sv
// rtl/clock_ui_pkg.sv - shared state encodings and timing defaults for the clock UI buttons
package clock_ui_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } btn_state_t;

  localparam int DEF_TICK_DIV        = 31500;
  localparam int DEF_DEBOUNCE_MS     = 20;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  localparam int MS_CNT_W = 10;

  function automatic bit ms_param_ok(input int v);
    return (v >= 1) && (v <= 1023);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running prescaler, one-cycle tick every TICK_DIV clocks
module ms_tick_gen
  import clock_ui_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic video_clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("ms_tick_gen: TICK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_repeat_ctrl.sv
// rtl/button_repeat_ctrl.sv - debounced button with delayed auto-repeat increment pulses
module button_repeat_ctrl
  import clock_ui_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic video_clk,
  input  logic reset_n,
  input  logic button_in,
  input  logic repeat_en,
  output logic pulse_out,
  output logic pressed,
  output logic repeating
);

  if (!ms_param_ok(DEBOUNCE_MS) || !ms_param_ok(REPEAT_DELAY_MS) || !ms_param_ok(REPEAT_RATE_MS))
  begin : g_bad_param
    $error("button_repeat_ctrl: timing parameters must lie in 1..1023");
  end

  localparam logic [MS_CNT_W-1:0] DB_LAST    = MS_CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [MS_CNT_W-1:0] DELAY_LAST = MS_CNT_W'(REPEAT_DELAY_MS - 1);
  localparam logic [MS_CNT_W-1:0] RATE_LAST  = MS_CNT_W'(REPEAT_RATE_MS - 1);

  logic                sync1_q, sync_q;
  logic                tick;
  btn_state_t          state_q, state_d;
  logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic                pulse_q, pulse_d;
  logic                pressed_q, repeating_q;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .video_clk (video_clk),
    .reset_n   (reset_n),
    .tick      (tick)
  );

  // A sync=0 exit always wins over a tick arriving in the same cycle.
  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d  = PRESS_DB;
          ms_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!sync_q) begin
          state_d  = IDLE;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_cnt_q == DB_LAST) begin
            state_d  = HELD;
            ms_cnt_d = '0;
            pulse_d  = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!sync_q) begin
          state_d  = RELEASE_DB;
          ms_cnt_d = '0;
        end else if (!repeat_en) begin
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_cnt_q == DELAY_LAST) begin
            state_d  = REPEAT;
            ms_cnt_d = '0;
            pulse_d  = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!sync_q) begin
          state_d  = RELEASE_DB;
          ms_cnt_d = '0;
        end else if (!repeat_en) begin
          state_d  = HELD;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_cnt_q == RATE_LAST) begin
            ms_cnt_d = '0;
            pulse_d  = 1'b1;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        if (sync_q) begin
          state_d  = HELD;
          ms_cnt_d = '0;
        end else if (tick) begin
          if (ms_cnt_q == DB_LAST) begin
            state_d  = IDLE;
            ms_cnt_d = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        ms_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= IDLE;
      ms_cnt_q    <= '0;
      pulse_q     <= 1'b0;
      pressed_q   <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      sync1_q     <= button_in;
      sync_q      <= sync1_q;
      state_q     <= state_d;
      ms_cnt_q    <= ms_cnt_d;
      pulse_q     <= pulse_d;
      pressed_q   <= (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_DB);
      repeating_q <= (state_d == REPEAT);
    end
  end

  assign pulse_out = pulse_q;
  assign pressed   = pressed_q;
  assign repeating = repeating_q;

endmodule

// File: doc/button_repeat_ctrl.md
BUTTON_REPEAT_CTRL -- requirements
Module: button_repeat_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 31500, video_clk cycles per 1 ms tick (31.5 MHz clock).
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, ticks of stable level needed to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_DELAY_MS, default 500, ticks from an accepted press to the first repeat pulse.
REQ-004 SHALL have parameter REPEAT_RATE_MS, default 100, ticks between consecutive repeat pulses.
REQ-005 SHALL have port video_clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port button_in, input, 1, raw asynchronous button level, high = pressed.
REQ-008 SHALL have port repeat_en, input, 1, synchronous level; when high, auto-repeat is allowed.
REQ-009 SHALL have port pulse_out, output, 1, one-cycle increment pulse that feeds the clock-adjust inputs.
REQ-010 SHALL have port pressed, output, 1, debounced button level.
REQ-011 SHALL have port repeating, output, 1, high while auto-repeat is active.

Function
REQ-012 SHALL pass button_in through a 2-flop synchronizer; all FSM decisions use the synchronized level (sync).
REQ-013 SHALL free-run a prescaler from 0 to TICK_DIV-1 that raises tick for one cycle at count TICK_DIV-1, then wraps to 0.
REQ-014 SHALL use FSM states IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB and a 10-bit tick counter ms_cnt.
REQ-015 SHALL, in IDLE with sync=1: go to PRESS_DB and set ms_cnt=0.
REQ-016 SHALL, in PRESS_DB with sync=0: return to IDLE with no pulse (glitch rejected); otherwise increment ms_cnt on each tick.
REQ-017 SHALL, in PRESS_DB on the DEBOUNCE_MS-th tick: go to HELD, clear ms_cnt, and issue one pulse.
REQ-018 SHALL, in HELD with sync=0: go to RELEASE_DB and clear ms_cnt.
REQ-019 SHALL, in HELD with repeat_en=1 and sync=1 on the REPEAT_DELAY_MS-th tick: go to REPEAT, clear ms_cnt, and issue one pulse.
REQ-020 SHALL, in HELD with repeat_en=0: hold ms_cnt at 0 and issue no further pulses until release.
REQ-021 SHALL, in REPEAT: go to RELEASE_DB when sync=0; go to HELD with ms_cnt cleared when repeat_en=0; otherwise issue a pulse and clear ms_cnt on every REPEAT_RATE_MS-th tick, indefinitely.
REQ-022 SHALL, in RELEASE_DB with sync=1: go to HELD with ms_cnt cleared and no pulse (release bounce absorbed).
REQ-023 SHALL, in RELEASE_DB on the DEBOUNCE_MS-th tick of sync=0: go to IDLE.
REQ-024 SHALL register pulse_out so it is high exactly one cycle, in the cycle after the decision edge; it is never high on two consecutive cycles.
REQ-025 SHALL drive pressed=1 in HELD, REPEAT and RELEASE_DB, repeating=1 only in REPEAT, and both registered.
REQ-026 SHALL apply the sync=0 exit first when a sync change and a tick arrive in the same cycle; the tick is not counted.
REQ-027 SHALL accept each timing parameter only in the range 1..1023; out-of-range values are an elaboration error.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force state=IDLE, synchronizer flops, prescaler and ms_cnt to 0, and pulse_out, pressed and repeating to 0.
REQ-029 SHALL, after reset_n rises with button_in held high, treat the button as a new press needing a full debounce (no spurious pulse before then).

Structure
REQ-030 SHALL place the FSM state encodings and the default timing constants in shared package clock_ui_pkg.
REQ-031 SHALL implement the prescaler as sub-module ms_tick_gen (parameter TICK_DIV, output tick), so the top level can share one instance across all five buttons.

Verification (TICK_DIV=4, DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2; tick 1 = first tick after sync rises)
REQ-032 SHALL check a clean hold for 41 ticks with repeat_en=1 -> exactly 18 pulses, at ticks 3, 8, 10, 12, ... 40; repeating=1 from tick 8.
REQ-033 SHALL check a high glitch of 2 ticks then low -> 0 pulses; pressed stays 0; state returns to IDLE.
REQ-034 SHALL check an accepted press, then 2 ticks low, then high again -> no extra pulse; pressed stays 1.
REQ-035 SHALL check a 41-tick hold with repeat_en=0 -> exactly 1 pulse (tick 3); repeating stays 0.
REQ-036 SHALL check reset_n pulsed low mid-REPEAT with the button held -> all outputs 0 immediately; after release of reset, the next pulse arrives exactly 3 ticks after sync is seen high.
REQ-037 SHALL check repeat_en dropped during REPEAT -> repeating=0 the next cycle and no further pulses while held.
